// File: rtl/nn_pkg.sv
// Shared parameters and FSM state type for the NN input loader and NN core.
// Optional binarization is enabled by defining NN_LOADER_BINARIZE_EN.
package nn_pkg;

    localparam int PIXELS  = 784;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

`ifdef NN_LOADER_BINARIZE_EN
    localparam int THRESH = 128;

    function automatic logic [DATA_W-1:0] binarize(input logic [DATA_W-1:0] pix);
        if (pix >= DATA_W'(THRESH)) begin
            binarize = {DATA_W{1'b1}};
        end else begin
            binarize = {DATA_W{1'b0}};
        end
    endfunction
`endif

endpackage

// File: rtl/nn_input_ram.sv
// PIXELS x DATA_W input buffer: one synchronous write port, one registered read port.
// Reads beyond the frame return zero; the array itself is never cleared.
module nn_input_ram
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [PIXELS];
    logic [DATA_W-1:0] rdata_r;

    // write port; the loader guarantees waddr < PIXELS
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port with out-of-frame addresses returning zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (raddr < ADDR_W'(PIXELS)) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= {DATA_W{1'b0}};
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/nn_input_loader.sv
// Drains a captured 28x28 frame into the local input buffer and hands it to the NN core.
// Define NN_LOADER_BINARIZE_EN to store thresholded pixels instead of raw values.
module nn_input_loader
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_done,
    output logic              cap_read_enable,
    input  logic [DATA_W-1:0] cap_read_data,
    input  logic              cap_read_valid,
    output logic              nn_start,
    input  logic              nn_done,
    input  logic [ADDR_W-1:0] nn_addr,
    output logic [DATA_W-1:0] nn_pixel,
    output logic              busy,
    output logic              loaded,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] pixel_count
);

    localparam int                GAP_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] NUM_PIX  = ADDR_W'(PIXELS);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT - 1);

    loader_state_t     state_r, state_next_s;
    logic              cap_done_r, armed_r;
    logic              en_r, en_d_r;
    logic [ADDR_W-1:0] issue_cnt_r, pix_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              nn_start_r, busy_r, loaded_r, timeout_err_r;
    logic              rise_s, accept_s, timeout_s;
    logic [DATA_W-1:0] wdata_s;

    // armed_r masks the first cycle after reset so a level held through reset is not an edge
    assign rise_s    = armed_r & capture_done & ~cap_done_r;
    assign accept_s  = (state_r == LOAD) & cap_read_valid & en_d_r & (pix_cnt_r < NUM_PIX);
    assign timeout_s = (state_r == LOAD) & ~accept_s & (gap_cnt_r == GAP_LAST);

`ifdef NN_LOADER_BINARIZE_EN
    assign wdata_s = binarize(cap_read_data);
`else
    assign wdata_s = cap_read_data;
`endif

    // next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) state_next_s = LOAD;
                else        state_next_s = IDLE;
            end
            LOAD: begin
                if (accept_s && (pix_cnt_r == LAST_PIX)) state_next_s = START;
                else if (timeout_s)                      state_next_s = IDLE;
                else                                     state_next_s = LOAD;
            end
            START: state_next_s = RUN;
            RUN: begin
                if (nn_done) state_next_s = IDLE;
                else         state_next_s = RUN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state, edge detector, request/beat/gap counters and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= IDLE;
            cap_done_r    <= 1'b0;
            armed_r       <= 1'b0;
            en_r          <= 1'b0;
            en_d_r        <= 1'b0;
            issue_cnt_r   <= {ADDR_W{1'b0}};
            pix_cnt_r     <= {ADDR_W{1'b0}};
            gap_cnt_r     <= {GAP_W{1'b0}};
            nn_start_r    <= 1'b0;
            busy_r        <= 1'b0;
            loaded_r      <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cap_done_r <= capture_done;
            armed_r    <= 1'b1;
            en_d_r     <= en_r;
            busy_r     <= (state_next_s != IDLE);
            nn_start_r <= (state_r == LOAD) && (state_next_s == START);
            if ((state_r == IDLE) && (state_next_s == LOAD)) begin
                en_r          <= 1'b1;
                issue_cnt_r   <= {ADDR_W{1'b0}};
                pix_cnt_r     <= {ADDR_W{1'b0}};
                gap_cnt_r     <= {GAP_W{1'b0}};
                loaded_r      <= 1'b0;
                timeout_err_r <= 1'b0;
            end else if (state_r == LOAD) begin
                // issue count stops at PIXELS because en_r drops on the last request
                if (en_r) begin
                    issue_cnt_r <= issue_cnt_r + ADDR_W'(1);
                    en_r        <= (issue_cnt_r < LAST_PIX);
                end
                if (accept_s) begin
                    pix_cnt_r <= pix_cnt_r + ADDR_W'(1);
                    gap_cnt_r <= {GAP_W{1'b0}};
                end else if (gap_cnt_r < GAP_MAX) begin
                    gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                end
                if (timeout_s) begin
                    timeout_err_r <= 1'b1;
                    en_r          <= 1'b0;
                end
                if (state_next_s == START) begin
                    loaded_r <= 1'b1;
                end
            end else begin
                en_r <= 1'b0;
            end
        end
    end

    nn_input_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (accept_s & reset),
        .waddr (pix_cnt_r),
        .wdata (wdata_s),
        .raddr (nn_addr),
        .rdata (nn_pixel)
    );

    assign cap_read_enable = en_r;
    assign nn_start        = nn_start_r;
    assign busy            = busy_r;
    assign loaded          = loaded_r;
    assign timeout_err     = timeout_err_r;
    assign pixel_count     = pix_cnt_r;

endmodule

// File: tb/tb_nn_input_loader.sv
// Self-checking bench for nn_input_loader: cycle model plus directed literal checks.
module tb_nn_input_loader;
    import nn_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              capture_done = 1'b0;
    logic              cap_read_valid = 1'b0;
    logic [DATA_W-1:0] cap_read_data = '0;
    logic              nn_done = 1'b0;
    logic [ADDR_W-1:0] nn_addr = '0;
    logic              cap_read_enable, nn_start, busy, loaded, timeout_err;
    logic [DATA_W-1:0] nn_pixel;
    logic [ADDR_W-1:0] pixel_count;

    int cyc = 0, checks = 0, errors = 0;
    int resp_cnt = 0, resp_limit = 1000000, resp_mode = 0, en_cnt = 0;
    bit sticky = 1'b0, chk_on = 1'b0;

    nn_input_loader dut (
        .clk(clk), .reset(reset), .capture_done(capture_done),
        .cap_read_enable(cap_read_enable), .cap_read_data(cap_read_data),
        .cap_read_valid(cap_read_valid), .nn_start(nn_start), .nn_done(nn_done),
        .nn_addr(nn_addr), .nn_pixel(nn_pixel), .busy(busy), .loaded(loaded),
        .timeout_err(timeout_err), .pixel_count(pixel_count)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] stored(input logic [DATA_W-1:0] d);
`ifdef NN_LOADER_BINARIZE_EN
        return (d >= 8'd128) ? 8'hFF : 8'h00;
`else
        return d;
`endif
    endfunction

    // Upstream capture stage: answers each request one cycle later, optionally giving up.
    initial begin
        bit en_seen;
        forever begin
            @(negedge clk);
            en_seen = (cap_read_enable === 1'b1);
            @(posedge clk);
            #1;
            if (en_seen && resp_cnt < resp_limit) begin
                cap_read_valid = 1'b1;
                if (resp_mode == 0) cap_read_data = DATA_W'(resp_cnt % 256);
                else cap_read_data = (resp_cnt % 2 == 0) ? 8'd127 : 8'd128;
                resp_cnt++;
            end else begin
                cap_read_valid = sticky;
                cap_read_data  = 8'hA5;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cap_read_enable === 1'b1) en_cnt++;
    end

    // Reference model: phase + load start cycle; enables follow from the cycle offset.
    int  m_phase = 0, m_c = 0, m_cnt = 0, m_gap = 0;
    bit  m_loaded = 0, m_err = 0, m_prev_cd = 0, m_armed = 0, m_en_t = 0, m_en_tm1 = 0, m_start = 0;
    logic [DATA_W-1:0] m_mem [PIXELS];
    bit  m_known [PIXELS];
    logic [DATA_W-1:0] m_pix = '0;
    bit  m_pix_known = 1'b0;

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("enable", cap_read_enable, m_en_t);
            check("nn_start", nn_start, m_start);
            check("busy", busy, m_phase != 0);
            check("loaded", loaded, m_loaded);
            check("timeout_err", timeout_err, m_err);
            check("pixel_count", pixel_count, m_cnt);
            if (m_pix_known) check("nn_pixel", nn_pixel, m_pix);
        end
        if (!reset) begin
            m_phase = 0; m_cnt = 0; m_gap = 0; m_loaded = 0; m_err = 0;
            m_prev_cd = 0; m_armed = 0; m_en_t = 0; m_en_tm1 = 0; m_start = 0;
            m_pix = '0; m_pix_known = 1'b1;
        end else begin
            bit rise;
            int off;
            rise = m_armed && capture_done && !m_prev_cd;
            m_prev_cd = capture_done;
            m_armed = 1;
            if (nn_addr < ADDR_W'(PIXELS)) begin
                m_pix = m_mem[nn_addr]; m_pix_known = m_known[nn_addr];
            end else begin
                m_pix = '0; m_pix_known = 1'b1;
            end
            m_start = 0;
            case (m_phase)
                0: if (rise) begin
                    m_phase = 1; m_c = cyc; m_cnt = 0; m_gap = 0; m_loaded = 0; m_err = 0;
                end
                1: if (cap_read_valid && m_en_tm1) begin
                    m_mem[m_cnt] = stored(cap_read_data);
                    m_known[m_cnt] = 1'b1;
                    m_cnt++;
                    m_gap = 0;
                    if (m_cnt == PIXELS) begin m_phase = 2; m_start = 1; m_loaded = 1; end
                end else begin
                    m_gap++;
                    if (m_gap == TIMEOUT) begin m_phase = 0; m_err = 1; end
                end
                2: m_phase = 3;
                default: if (nn_done) m_phase = 0;
            endcase
            off = cyc + 1 - m_c;
            m_en_tm1 = m_en_t;
            m_en_t = (m_phase == 1) && off >= 1 && off <= PIXELS;
        end
        chk_on = 1'b1;
    end

    task automatic wait_start(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            @(negedge clk);
            if (nn_start === 1'b1) at = cyc;
        end
        check("nn_start_seen", at >= 0, 1);
    endtask

    task automatic read_pix(input int addr, input string name, input logic [7:0] exp);
        tick();
        nn_addr = ADDR_W'(addr);
        repeat (2) @(negedge clk);
        check(name, nn_pixel, exp);
    endtask

    task automatic begin_load(input int mode, input int limit, output int c);
        capture_done = 1'b0;
        resp_mode = mode; resp_limit = limit; resp_cnt = 0;
        tick(); tick();
        capture_done = 1'b1;
        c = cyc;
    endtask

    initial begin
        int c, at, e0, s0;
        // reset with capture_done already high: level, not an edge
        reset = 1'b0; capture_done = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_count", pixel_count, 0);
        check("level_no_load", cap_read_enable, 0);

        // 1: full load of i mod 256
        e0 = en_cnt;
        begin_load(0, 1000000, c);
        wait_start(1000, at);
        check("t1_start_latency", at - c, 786);
        check("t1_enables", en_cnt - e0, 784);
`ifdef NN_LOADER_BINARIZE_EN
        read_pix(300, "t1_pix300", 8'h00);
        read_pix(200, "t1_pix200", 8'hFF);
`else
        read_pix(300, "t1_pix300", 8'd44);
        read_pix(783, "t1_pix783", 8'd15);
`endif
        read_pix(800, "t1_pix_oor", 8'd0);

        // 3/5: sticky valid and a new capture edge during RUN are both ignored
        e0 = en_cnt;
        sticky = 1'b1;
        capture_done = 1'b0; tick(); tick();
        capture_done = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check("t5_run_busy", busy, 1);
        check("t5_run_loaded", loaded, 1);
        check("t3_run_count", pixel_count, 784);
        check("t5_no_requests", en_cnt - e0, 0);
        tick(); nn_done = 1'b1; tick(); nn_done = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("t3_idle_busy", busy, 0);
        check("t3_idle_count", pixel_count, 784);
        check("t3_idle_loaded", loaded, 1);

        // 2: alternating 127/128, loaded drops at LOAD entry
        begin_load(1, 1000000, c);
        repeat (2) @(negedge clk);
        check("t5_loaded_drop", loaded, 0);
        check("t5_reload_busy", busy, 1);
        wait_start(1000, at);
        check("t2_start_latency", at - c, 786);
        check("t2_count", pixel_count, 784);
`ifdef NN_LOADER_BINARIZE_EN
        read_pix(0, "t2_pix0", 8'h00);
        read_pix(1, "t2_pix1", 8'hFF);
`else
        read_pix(0, "t2_pix0", 8'd127);
        read_pix(1, "t2_pix1", 8'd128);
`endif
        tick(); nn_done = 1'b1; tick(); nn_done = 1'b0;
        sticky = 1'b0;

        // 4: upstream stops after 100 beats (beats c+2..c+101)
        s0 = -1;
        begin_load(0, 100, c);
        at = -1;
        for (int i = 0; i < 1500 && at < 0; i++) begin
            @(negedge clk);
            if (nn_start === 1'b1) s0 = cyc;
            if (timeout_err === 1'b1) at = cyc;
        end
        check("t4_err_seen", at >= 0, 1);
        // last beat at c+101, 1024 idle cycles c+102..c+1125, flag registered at c+1126
        check("t4_err_latency", at - c, 1126);
        check("t4_busy", busy, 0);
        check("t4_loaded", loaded, 0);
        check("t4_count", pixel_count, 100);
        check("t4_no_start", s0, -1);

        // 6: reset mid-load at beat 400, then clean reload
        begin_load(0, 1000000, c);
        repeat (2) @(negedge clk);
        check("t6_err_cleared", timeout_err, 0);
        at = -1;
        for (int i = 0; i < 1000 && at < 0; i++) begin
            @(negedge clk);
            if (pixel_count == 10'd400) at = cyc;
        end
        check("t6_beat400_seen", at >= 0, 1);
        tick(); reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", pixel_count, 0);
        check("t6_rst_enable", cap_read_enable, 0);
        check("t6_rst_pixel", nn_pixel, 0);
        check("t6_rst_start", nn_start, 0);
        tick(); reset = 1'b1;
        begin_load(0, 1000000, c);
        wait_start(1000, at);
        check("t6_start_latency", at - c, 786);
        check("t6_count", pixel_count, 784);
`ifdef NN_LOADER_BINARIZE_EN
        read_pix(300, "t6_pix300", 8'h00);
`else
        read_pix(300, "t6_pix300", 8'd44);
`endif
        tick(); nn_done = 1'b1; tick(); nn_done = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_input_loader.md
# nn_input_loader

Downstream neighbour of the 28x28 frame-capture stage. On each new capture it drains the 784 captured pixels over the capture block's read port and writes them, optionally binarized, into a local input buffer. It then pulses a start to the neural-network core and exposes the buffer through a registered random-access read port for the core's input layer.

## Interface
- `PIXELS`, 784: pixels per frame (28x28).
- `DATA_W`, 8: pixel width.
- `ADDR_W`, 10: buffer address width; must satisfy 2^ADDR_W >= PIXELS.
- `TIMEOUT`, 1024: maximum idle cycles between accepted beats during LOAD.
- `THRESH`, 128: binarization threshold, used only with the macro.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `capture_done`  in  1  level from the capture stage; a rising edge starts a load.
- `cap_read_enable`  out  1  read request to the capture stage.
- `cap_read_data`  in  DATA_W  pixel returned by the capture stage.
- `cap_read_valid`  in  1  pixel valid from the capture stage. It is sticky and may stay high with no request outstanding.
- `nn_start`  out  1  one-cycle pulse when the buffer is complete.
- `nn_done`  in  1  one-cycle pulse from the NN core when inference finishes.
- `nn_addr`  in  ADDR_W  buffer read address from the NN core.
- `nn_pixel`  out  DATA_W  registered buffer read data.
- `busy`  out  1  high in any state other than IDLE.
- `loaded`  out  1  high while the buffer holds a complete frame.
- `timeout_err`  out  1  sticky error flag.
- `pixel_count`  out  ADDR_W  number of pixels accepted in the current or last load.

## Operation
- FSM states:
  - IDLE: waits for the start condition.
  - LOAD: issues reads and accepts beats.
  - START: drives `nn_start`.
  - RUN: waits for `nn_done`.
- Edge detect: `capture_done` is registered and compared with its previous value. A rising edge matters only in IDLE; edges seen in any other state are dropped, not queued.
- IDLE → LOAD on a rising edge. Entry clears `pixel_count`, the issue counter, `loaded` and `timeout_err`.
- LOAD:
  - `cap_read_enable` is high while issue count < PIXELS, giving exactly PIXELS contiguous requests.
  - A beat is accepted in cycle t only if `cap_read_valid`=1 and `cap_read_enable` was 1 in cycle t-1. Sticky valid without a prior request is ignored.
  - An accepted beat is written to buffer[`pixel_count`] and `pixel_count` increments.
- LOAD → START when `pixel_count` reaches PIXELS.
- LOAD → IDLE on timeout: the gap counter hits TIMEOUT with no accepted beat. Sets `timeout_err`, leaves `loaded`=0 and stops requesting.
- START: `nn_start`=1 for exactly one cycle, `loaded`=1, then → RUN.
- RUN → IDLE on `nn_done`. `loaded` stays 1 until the next load begins. `nn_done` in any other state is ignored.
- Read port: `nn_pixel` <= buffer[`nn_addr`] every cycle. An address >= PIXELS returns 0. Reads during LOAD return whichever value the buffer currently holds.
- Counters saturate and never wrap. The buffer write address is always < PIXELS.

## Timing
- Reset values: FSM=IDLE, `cap_read_enable`=0, `nn_start`=0, `nn_pixel`=0, `busy`=0, `loaded`=0, `timeout_err`=0, `pixel_count`=0, edge register=0. Buffer contents are not cleared.
- A reset mid-LOAD or mid-RUN returns to IDLE in the next cycle with no `nn_start`. A `capture_done` already high at reset release is a level, not an edge, and does not trigger a load.
- Edge seen in cycle c: enables are high in c+1..c+PIXELS, beats are accepted in c+2..c+PIXELS+1, and `nn_start`=1 in c+PIXELS+2. For PIXELS=784, `nn_start` is at c+786.
- The upstream return latency is exactly one cycle. A missing beat is not retried; it leaves `pixel_count` short and eventually triggers the timeout.
- `nn_pixel` latency: 1 cycle from `nn_addr`.
- `busy` is registered and reflects the current state.

## Configuration
- Macro `NN_LOADER_BINARIZE_EN`.
- Defined: stored pixel = (`cap_read_data` >= THRESH) ? {DATA_W{1'b1}} : 0.
- Undefined: `cap_read_data` is stored unmodified and THRESH is unused.
- Port list and timing are identical in both builds.

## Structure
- Package `nn_pkg` holds PIXELS, DATA_W, ADDR_W and the FSM state enum `loader_state_t` (IDLE, LOAD, START, RUN). The NN core shares PIXELS and ADDR_W from this package.
- Sub-module `nn_input_ram`: single-write, single-read synchronous RAM of PIXELS x DATA_W with registered read and out-of-range read returning 0.
- The FSM, counters and optional binarizer stay in the top module.

## Test plan
1. Reset, then drive a `capture_done` rise with a model returning pixel i = i mod 256 → 784 enables, `nn_start` at c+786, and `nn_pixel` at addr 300 = 44 (300 mod 256) in the passthrough build.
2. Binarize build, pixels alternating 127/128 → buffer holds 0x00/0xFF alternately, `pixel_count`=784.
3. Hold `cap_read_valid`=1 with no requests while IDLE and RUN → no writes and `pixel_count` unchanged.
4. Model stops returning data after 100 beats → `timeout_err`=1 1024 cycles after the last beat, IDLE, `loaded`=0, no `nn_start`.
5. Drive a second `capture_done` rise during RUN → ignored. After `nn_done`, a new rise reloads and `loaded` drops to 0 at LOAD entry.
6. Assert `reset`=0 at beat 400 → next cycle all outputs are at reset values, and a subsequent rise reloads all 784 pixels cleanly.
